obi_mem_arbiter: RTL and testbench
==================================

Name: obi_mem_arbiter

Overview:
- Round-robin arbiter that shares one OBI-style memory port (req/gnt/rvalid) among NUM_REQ requesters, e.g. core instruction and data ports in front of the memory subsystem.
- Keeps the memory-side request stable until it is granted.
- Tracks outstanding transactions in an in-order ID FIFO and routes each rvalid/rdata back to the requester that issued it.

Parameters:
NUM_REQ, 2, number of requester ports (≥2)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8
MAX_OUTSTANDING, 4, ID FIFO depth (power of two, ≥1)

Ports:
clk_i  in  1  single clock, rising edge
rst_i  in  1  synchronous, active-high reset
req_i  in  NUM_REQ  per-requester request
addr_i  in  NUM_REQ*ADDR_WIDTH  per-requester address, slice k = requester k
we_i  in  NUM_REQ  per-requester write enable
be_i  in  NUM_REQ*DATA_WIDTH/8  per-requester byte enables
wdata_i  in  NUM_REQ*DATA_WIDTH  per-requester write data
gnt_o  out  NUM_REQ  per-requester grant, one-hot or zero
rvalid_o  out  NUM_REQ  per-requester response valid, one-hot or zero
rdata_o  out  DATA_WIDTH  response data, shared by all requesters
mem_req_o  out  1  memory request
mem_addr_o  out  ADDR_WIDTH  memory address
mem_we_o  out  1  memory write enable
mem_be_o  out  DATA_WIDTH/8  memory byte enables
mem_wdata_o  out  DATA_WIDTH  memory write data
mem_gnt_i  in  1  memory grant
mem_rvalid_i  in  1  memory response valid, in request order
mem_rdata_i  in  DATA_WIDTH  memory read data
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current FIFO occupancy
err_o  out  1  sticky protocol error

Behaviour:
- Registered state:
  - rr_ptr: next priority index.
  - state: ARB or LOCKED, plus lock_idx.
  - ID FIFO: MAX_OUTSTANDING entries of $clog2(NUM_REQ) bits, with head/tail/count.
  - err flag.
- Reset (rst_i high at a clock edge):
  - rr_ptr=0, state=ARB, FIFO empty (count=0), err_o=0.
  - While rst_i is high, mem_req_o, gnt_o and rvalid_o are forced to 0.
- full = (count==MAX_OUTSTANDING).
- ARB state:
  - sel = first k with req_i[k]=1, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - mem_req_o = |req_i & !full.
  - mem_* fields are muxed from requester sel, combinationally.
- LOCKED state:
  - sel = lock_idx; mem_req_o = 1, regardless of full.
  - Full cannot rise while locked, because there is no push without a grant.
- Handshake = mem_req_o & mem_gnt_i:
  - gnt_o[sel]=1 in the same cycle (zero added latency); all other gnt_o bits are 0.
  - FIFO pushes sel at tail.
  - rr_ptr <= (sel+1) mod NUM_REQ.
  - state <= ARB.
- mem_req_o=1 & mem_gnt_i=0: state <= LOCKED, lock_idx <= sel. The selection, and therefore mem_addr/we/be/wdata, is held until granted.
- Requester rule: requesters keep req_i high until gnt_o. Deasserting req_i[lock_idx] while LOCKED is a protocol violation; the arbiter still holds mem_req_o and sets err_o.
- Response path:
  - mem_rvalid_i=1 with count>0: rvalid_o[FIFO head]=1 in the same cycle, rdata_o=mem_rdata_i, FIFO pops.
  - rdata_o is don't-care when no rvalid_o bit is high; it is driven with mem_rdata_i at all times.
- Spurious response: mem_rvalid_i=1 with count==0 → response dropped, all rvalid_o=0, err_o set. err_o stays 1 until reset.
- Push and pop in the same cycle: count unchanged. A pop does not relieve full in the same cycle; full is evaluated from the registered count.
- A response may arrive in the cycle after its grant at the earliest. A same-cycle gnt+rvalid pairs the rvalid with the older entry.
- outstanding_o = count, registered.
- Reset mid-operation: FIFO contents are discarded. Responses arriving after reset for pre-reset requests are treated as spurious (err_o).

Test Plan:
- Single requester: req_i=2'b01, addr_i[0]=0x100, mem_gnt_i=1, mem_rvalid_i one cycle later with rdata 0xDEADBEEF → gnt_o=01 in request cycle; next cycle rvalid_o=01, rdata_o=0xDEADBEEF; outstanding_o 0→1→0.
- Fairness: req_i=2'b11 held, mem_gnt_i=1 continuously, responses one cycle later → gnt_o sequence 01,10,01,10; rvalid_o follows the same order one cycle later.
- Lock: req_i=2'b01, mem_gnt_i=0 for 3 cycles, req_i[1] raised in cycle 1 with addr 0x200 → mem_addr_o stays 0x100 all 3 cycles; grant in cycle 4 goes to requester 0; requester 1 is granted next.
- Full: MAX_OUTSTANDING=4, no mem_rvalid_i, req_i=2'b01 held → 4 grants, then mem_req_o=0 and outstanding_o=4. One rvalid → mem_req_o=1 the following cycle.
- Out-of-order requesters: grants 0,1,1 with delayed responses 0xA,0xB,0xC → rvalid_o 01,10,10 with matching data; simultaneous push/pop keeps the count constant.
- Errors/reset: rvalid with count==0 → err_o=1, no rvalid_o. Assert rst_i with outstanding_o=2 → next cycle outstanding_o=0, err_o=0, mem_req_o=0 while rst_i is high.

Source files
------------

// File: rtl/obi_mem_arbiter.sv
// Round-robin arbiter sharing one OBI-style memory port among NUM_REQ requesters.
// An in-order ID FIFO routes each memory response back to the requester that issued it.
module obi_mem_arbiter #(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NUM_REQ-1:0]                    req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]         addr_i,
    input  logic [NUM_REQ-1:0]                    we_i,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]       be_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]         wdata_i,
    output logic [NUM_REQ-1:0]                    gnt_o,
    output logic [NUM_REQ-1:0]                    rvalid_o,
    output logic [DATA_WIDTH-1:0]                 rdata_o,
    output logic                                  mem_req_o,
    output logic [ADDR_WIDTH-1:0]                 mem_addr_o,
    output logic                                  mem_we_o,
    output logic [DATA_WIDTH/8-1:0]               mem_be_o,
    output logic [DATA_WIDTH-1:0]                 mem_wdata_o,
    input  logic                                  mem_gnt_i,
    input  logic                                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                 mem_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_o,
    output logic                                  err_o
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W    = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [0:0] {ST_ARB, ST_LOCKED} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [CNT_W-1:0]   count_q;
    logic               err_q;

    logic [IDX_W-1:0]   arb_sel, sel;
    logic               arb_any, full, hs, push, pop, spurious, lock_drop;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [BE_WIDTH-1:0]   be_arr    [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        return IDX_W'(s % NUM_REQ);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign addr_arr[k]  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign be_arr[k]    = be_i[k*BE_WIDTH +: BE_WIDTH];
        assign wdata_arr[k] = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // First active requester at or after the round-robin pointer
    always_comb begin
        arb_sel = rr_ptr_q;
        arb_any = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!arb_any && req_i[wrap_add(rr_ptr_q, i)]) begin
                arb_sel = wrap_add(rr_ptr_q, i);
                arb_any = 1'b1;
            end
        end
    end

    assign full      = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign hs        = mem_req_o && mem_gnt_i;
    assign push      = hs;
    assign pop       = !rst_i && mem_rvalid_i && (count_q != '0);
    assign spurious  = mem_rvalid_i && (count_q == '0);
    assign lock_drop = (state_q == ST_LOCKED) && !req_i[lock_idx_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_ARB;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // An ungranted request locks the selection until the memory accepts it
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        if (hs) begin
            state_d = ST_ARB;
        end else if (mem_req_o) begin
            state_d    = ST_LOCKED;
            lock_idx_d = sel;
        end
    end

    always_comb begin
        sel         = (state_q == ST_LOCKED) ? lock_idx_q : arb_sel;
        mem_req_o   = 1'b0;
        if (!rst_i) begin
            mem_req_o = (state_q == ST_LOCKED) ? 1'b1 : (arb_any && !full);
        end
        gnt_o       = (mem_req_o && mem_gnt_i) ? (NUM_REQ'(1) << sel) : '0;
        rvalid_o    = pop ? (NUM_REQ'(1) << fifo_q[head_q]) : '0;
        mem_addr_o  = addr_arr[sel];
        mem_we_o    = we_i[sel];
        mem_be_o    = be_arr[sel];
        mem_wdata_o = wdata_arr[sel];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (hs)   rr_ptr_q <= wrap_add(sel, 1);
            if (push) tail_q   <= ptr_inc(tail_q);
            if (pop)  head_q   <= ptr_inc(head_q);
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (spurious || lock_drop) err_q <= 1'b1;
        end
    end

    // ID storage needs no reset; validity is tracked by count_q
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[tail_q] <= sel;
    end

    assign rdata_o       = mem_rdata_i;
    assign outstanding_o = count_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Bench for obi_mem_arbiter: vector table, directed corner sequences and random traffic
// checked against a queue-based reference model.
module tb_obi_mem_arbiter;

    localparam int NREQ = 2;
    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0;
    logic [63:0] addr;
    logic [1:0]  we;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic [1:0]  gnt, rvalid;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [2:0]  outstanding;
    logic        err;

    logic [31:0] a_r  [NREQ];
    logic        we_r [NREQ];
    logic [3:0]  be_r [NREQ];
    logic [31:0] wd_r [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_pack
        assign addr[k*32 +: 32]  = a_r[k];
        assign we[k]             = we_r[k];
        assign be[k*4 +: 4]      = be_r[k];
        assign wdata[k*32 +: 32] = wd_r[k];
    end

    always #5 clk = ~clk;

    obi_mem_arbiter #(.NUM_REQ(NREQ), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .outstanding_o(outstanding), .err_o(err)
    );

    int n_pass = 0;
    int n_total = 0;

    // Reference model: queue of issuing requester IDs, priority pointer, pending (ungranted) requester
    int   mq[$];
    int   m_rr = 0;
    int   m_pend = -1;
    bit   m_err = 0;
    logic [1:0] last_eg;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step();
        int sel;
        bit mreq, full;
        logic [1:0] eg, erv;
        if (rst) begin
            chk("rst gnt", gnt, 0);
            chk("rst rvalid", rvalid, 0);
            chk("rst mem_req", mem_req, 0);
            chk("rst outstanding", outstanding, 64'(mq.size()));
            chk("rst err", err, m_err);
            mq.delete();
            m_rr = 0; m_pend = -1; m_err = 0; last_eg = '0;
            return;
        end
        full = (mq.size() == MAXO);
        sel = -1;
        if (m_pend >= 0) begin
            sel = m_pend;
            mreq = 1;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (sel < 0 && req[(m_rr + i) % NREQ]) sel = (m_rr + i) % NREQ;
            end
            mreq = (sel >= 0) && !full;
        end
        eg  = (mreq && mem_gnt) ? 2'(1 << sel) : 2'b00;
        erv = (mem_rvalid && mq.size() > 0) ? 2'(1 << mq[0]) : 2'b00;
        chk("gnt", gnt, eg);
        chk("rvalid", rvalid, erv);
        chk("mem_req", mem_req, mreq);
        chk("outstanding", outstanding, 64'(mq.size()));
        chk("err", err, m_err);
        if (mreq) begin
            chk("mem_addr", mem_addr, a_r[sel]);
            chk("mem_we", mem_we, we_r[sel]);
            chk("mem_be", mem_be, be_r[sel]);
            chk("mem_wdata", mem_wdata, wd_r[sel]);
        end
        if (erv != 0) chk("rdata", rdata, mem_rdata);
        last_eg = eg;
        if (m_pend >= 0 && !req[m_pend]) m_err = 1;
        if (mem_rvalid) begin
            if (mq.size() > 0) void'(mq.pop_front());
            else m_err = 1;
        end
        if (mreq && mem_gnt) begin
            mq.push_back(sel);
            m_rr = (sel + 1) % NREQ;
            m_pend = -1;
        end else if (mreq) begin
            m_pend = sel;
        end
    endtask

    // Drive one cycle's inputs after the edge, then check at the falling edge
    task automatic cyc(input logic r, input logic [1:0] rq, input logic g, input logic v, input logic [31:0] rd);
        @(posedge clk);
        #1;
        rst = r; req = rq; mem_gnt = g; mem_rvalid = v; mem_rdata = rd;
        @(negedge clk);
        model_step();
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic        g;
        logic        v;
        logic [31:0] rd;
        logic [1:0]  e_gnt;
        logic [1:0]  e_rv;
        logic        e_mreq;
        logic [2:0]  e_out;
    } vec_t;

    vec_t vt[10];
    logic [1:0] req_r;

    initial begin
        for (int k = 0; k < NREQ; k++) begin
            a_r[k] = 32'h100 * (k + 1); we_r[k] = 1'(k); be_r[k] = 4'hF; wd_r[k] = 32'h1000 + k;
        end
        vt[0] = '{0, 2'b01, 1, 0, 32'h0,        2'b01, 2'b00, 1, 3'd0};
        vt[1] = '{0, 2'b00, 1, 1, 32'hDEADBEEF, 2'b00, 2'b01, 0, 3'd1};
        vt[2] = '{0, 2'b00, 0, 0, 32'h0,        2'b00, 2'b00, 0, 3'd0};
        vt[3] = '{1, 2'b00, 0, 0, 32'h0,        2'b00, 2'b00, 0, 3'd0};
        vt[4] = '{0, 2'b11, 1, 0, 32'h0,        2'b01, 2'b00, 1, 3'd0};
        vt[5] = '{0, 2'b11, 1, 1, 32'h1,        2'b10, 2'b01, 1, 3'd1};
        vt[6] = '{0, 2'b11, 1, 1, 32'h2,        2'b01, 2'b10, 1, 3'd1};
        vt[7] = '{0, 2'b11, 1, 1, 32'h3,        2'b10, 2'b01, 1, 3'd1};
        vt[8] = '{0, 2'b00, 0, 1, 32'h4,        2'b00, 2'b10, 0, 3'd1};
        vt[9] = '{0, 2'b00, 0, 0, 32'h0,        2'b00, 2'b00, 0, 3'd0};

        cyc(1, 2'b00, 0, 0, 0);
        cyc(1, 2'b00, 0, 0, 0);
        foreach (vt[i]) begin
            cyc(vt[i].rst, vt[i].req, vt[i].g, vt[i].v, vt[i].rd);
            chk("vec gnt", gnt, vt[i].e_gnt);
            chk("vec rvalid", rvalid, vt[i].e_rv);
            chk("vec mem_req", mem_req, vt[i].e_mreq);
            chk("vec outstanding", outstanding, vt[i].e_out);
            if (vt[i].e_rv != 0) chk("vec rdata", rdata, vt[i].rd);
        end

        // Lock: selection and payload held while the memory stalls
        cyc(1, 2'b00, 0, 0, 0);
        cyc(0, 2'b01, 0, 0, 0); chk("lock addr0", mem_addr, 32'h100); chk("lock req0", mem_req, 1);
        cyc(0, 2'b11, 0, 0, 0); chk("lock addr1", mem_addr, 32'h100);
        cyc(0, 2'b11, 0, 0, 0); chk("lock addr2", mem_addr, 32'h100);
        cyc(0, 2'b11, 1, 0, 0); chk("lock gnt0", gnt, 2'b01); chk("lock addr3", mem_addr, 32'h100);
        cyc(0, 2'b10, 1, 0, 0); chk("lock gnt1", gnt, 2'b10); chk("lock addr4", mem_addr, 32'h200);
        cyc(0, 2'b00, 0, 1, 32'h11); chk("lock rv0", rvalid, 2'b01);
        cyc(0, 2'b00, 0, 1, 32'h22); chk("lock rv1", rvalid, 2'b10);
        cyc(0, 2'b00, 0, 0, 0); chk("lock err", err, 0);

        // Full: four grants, then the request is withheld until a pop is registered
        cyc(1, 2'b00, 0, 0, 0);
        for (int i = 0; i < MAXO; i++) begin
            cyc(0, 2'b01, 1, 0, 0); chk("full gnt", gnt, 2'b01);
        end
        cyc(0, 2'b01, 1, 0, 0); chk("full req", mem_req, 0); chk("full gnt0", gnt, 0); chk("full out", outstanding, 4);
        cyc(0, 2'b01, 1, 1, 32'h55); chk("full pop req", mem_req, 0); chk("full pop rv", rvalid, 2'b01);
        cyc(0, 2'b01, 1, 0, 0); chk("full reopen", mem_req, 1); chk("full reopen gnt", gnt, 2'b01); chk("full out3", outstanding, 3);
        for (int i = 0; i < MAXO; i++) begin
            cyc(0, 2'b00, 0, 1, 32'(i)); chk("full drain", rvalid, 2'b01);
        end
        cyc(0, 2'b00, 0, 0, 0); chk("full empty", outstanding, 0);

        // Responses routed in issue order with simultaneous push/pop
        cyc(1, 2'b00, 0, 0, 0);
        cyc(0, 2'b01, 1, 0, 0); chk("ooo g0", gnt, 2'b01);
        cyc(0, 2'b10, 1, 0, 0); chk("ooo g1", gnt, 2'b10);
        cyc(0, 2'b10, 1, 1, 32'hA); chk("ooo g2", gnt, 2'b10); chk("ooo rvA", rvalid, 2'b01);
        chk("ooo dA", rdata, 32'hA); chk("ooo out2", outstanding, 2);
        cyc(0, 2'b00, 0, 1, 32'hB); chk("ooo rvB", rvalid, 2'b10); chk("ooo dB", rdata, 32'hB); chk("ooo hold", outstanding, 2);
        cyc(0, 2'b00, 0, 1, 32'hC); chk("ooo rvC", rvalid, 2'b10); chk("ooo dC", rdata, 32'hC);
        cyc(0, 2'b00, 0, 0, 0); chk("ooo out0", outstanding, 0);

        // Spurious response, then reset with requests in flight
        cyc(1, 2'b00, 0, 0, 0);
        cyc(0, 2'b00, 0, 1, 32'h99); chk("spur rv", rvalid, 0);
        cyc(0, 2'b00, 0, 0, 0); chk("spur err", err, 1);
        cyc(0, 2'b01, 1, 0, 0);
        cyc(0, 2'b01, 1, 0, 0);
        cyc(1, 2'b01, 1, 0, 0); chk("rst out2", outstanding, 2); chk("rst req", mem_req, 0); chk("rst gnt", gnt, 0);
        cyc(1, 2'b01, 1, 0, 0); chk("rst out0", outstanding, 0); chk("rst err0", err, 0); chk("rst req2", mem_req, 0);
        cyc(0, 2'b00, 0, 1, 32'h77); chk("stale rv", rvalid, 0);
        cyc(0, 2'b00, 0, 0, 0); chk("stale err", err, 1);

        // Dropping a locked request keeps the memory request and flags an error
        cyc(1, 2'b00, 0, 0, 0);
        cyc(0, 2'b01, 0, 0, 0); chk("drop req", mem_req, 1);
        cyc(0, 2'b00, 0, 0, 0); chk("drop held", mem_req, 1); chk("drop addr", mem_addr, 32'h100);
        cyc(0, 2'b00, 0, 0, 0); chk("drop err", err, 1);
        cyc(1, 2'b00, 0, 0, 0);

        // Random protocol-respecting traffic
        req_r = '0;
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!req_r[k] && ($urandom % 2 == 1)) begin
                    req_r[k] = 1'b1;
                    a_r[k] = $urandom; we_r[k] = 1'($urandom); be_r[k] = 4'($urandom); wd_r[k] = $urandom;
                end
            end
            cyc(($urandom % 100) == 0, req_r, ($urandom % 4) != 0, (mq.size() > 0) && ($urandom % 2 == 1), $urandom);
            req_r = req_r & ~last_eg;
        end
        cyc(0, 2'b00, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
